// File: rtl/forward_transform_4x4_if.sv
// -----------------------------------------------------------------------------
// forward_transform_4x4_if
// Row-in / row-out handshake bundle for the 4x4 forward integer transform.
//
// Signals:
//   residual   one residual row, lane i at [(i+1)*PIXEL_WIDTH-1 -: PIXEL_WIDTH]
//   src_valid  residual holds a valid row
//   src_ready  transform accepts a row this cycle
//   coef       one coefficient row, same lane packing as residual
//   dst_valid  coef holds a valid row
//   dst_ready  downstream accepts coef this cycle
//   coef_last  marks the final (4th) coefficient row of a block
//
// Modports:
//   slave   transform side (consumes residual rows, produces coef rows)
//   master  environment side (produces residual rows, consumes coef rows)
// -----------------------------------------------------------------------------
interface forward_transform_4x4_if #(
  parameter int MB_SIZE     = 4,
  parameter int PIXEL_WIDTH = 8,
  parameter int COEF_WIDTH  = 16
);
  logic [PIXEL_WIDTH*MB_SIZE-1:0] residual;
  logic                           src_valid;
  logic                           src_ready;
  logic [COEF_WIDTH*MB_SIZE-1:0]  coef;
  logic                           dst_valid;
  logic                           dst_ready;
  logic                           coef_last;

  modport slave (
    input  residual, src_valid, dst_ready,
    output src_ready, coef, dst_valid, coef_last
  );

  modport master (
    output residual, src_valid, dst_ready,
    input  src_ready, coef, dst_valid, coef_last
  );
endinterface

// File: rtl/forward_transform_4x4.sv
// -----------------------------------------------------------------------------
// forward_transform_4x4
// 4x4 forward integer transform (H.264-style core transform, no scaling).
// Collects four residual rows, row-transforms each as it arrives, then emits
// four coefficient rows produced by the column transform, one per cycle.
//
// Ports:
//   clk     single clock, rising edge
//   reset   asynchronous, active-low reset
//   bypass  (only with FWD_TRANSFORM_BYPASS_EN) sampled with row 0; when set,
//           the block is passed through sign-extended instead of transformed
//   bus     forward_transform_4x4_if.slave handshake bundle
//
// Parameters:
//   MB_SIZE      lanes per row and rows per block; only 4 is supported
//   PIXEL_WIDTH  residual lane width, two's complement
//   COEF_WIDTH   coefficient lane width, must be >= PIXEL_WIDTH+6
//
// Optional feature macro: FWD_TRANSFORM_BYPASS_EN
//
// State  | meaning
// -------+----------------------------------------------------------
// COLLECT| src_ready=1; accept rows 0..3 into H, row 3 -> EMIT
// EMIT   | dst_valid=1; present coef row out_cnt, row 3 -> COLLECT
// -----------------------------------------------------------------------------
module forward_transform_4x4 #(
  parameter int MB_SIZE     = 4,
  parameter int PIXEL_WIDTH = 8,
  parameter int COEF_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef FWD_TRANSFORM_BYPASS_EN
  input  logic                    bypass,
`endif
  forward_transform_4x4_if.slave  bus
);

  localparam int PW = PIXEL_WIDTH;
  localparam int CW = COEF_WIDTH;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            in_cnt_q;
  logic [1:0]            out_cnt_q;
  logic                  accept_row;
  logic                  emit_row;

  logic signed [CW-1:0]  h_q   [MB_SIZE][MB_SIZE];
  logic signed [CW-1:0]  row_x [MB_SIZE];
  logic signed [CW-1:0]  row_y [MB_SIZE];
  logic signed [CW-1:0]  col_y [MB_SIZE];

`ifdef FWD_TRANSFORM_BYPASS_EN
  logic                  bypass_q;
  logic                  bypass_row;
`endif

  // Shared 4-point butterfly; k selects which output index is returned.
  // Headroom: row pass grows by 3 bits, column pass by 3 more, so CW >= PW+6
  // keeps every intermediate exact.
  function automatic logic signed [CW-1:0] butterfly(
    input logic signed [CW-1:0] x0,
    input logic signed [CW-1:0] x1,
    input logic signed [CW-1:0] x2,
    input logic signed [CW-1:0] x3,
    input logic [1:0]           k
  );
    logic signed [CW-1:0] s03, d03, s12, d12;
    logic signed [CW-1:0] y;
    s03 = x0 + x3;
    d03 = x0 - x3;
    s12 = x1 + x2;
    d12 = x1 - x2;
    case (k)
      2'd0:    y = s03 + s12;
      2'd1:    y = (d03 <<< 1) + d12;
      2'd2:    y = s03 - s12;
      default: y = d03 - (d12 <<< 1);
    endcase
    return y;
  endfunction

  assign accept_row = bus.src_valid & bus.src_ready;
  assign emit_row   = bus.dst_valid & bus.dst_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (accept_row && in_cnt_q == 2'd3) state_d = EMIT;
      EMIT:    if (emit_row && out_cnt_q == 2'd3)  state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // src_ready is also gated by reset so nothing is offered while held in reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.src_ready = 1'b0;
    bus.dst_valid = 1'b0;
    bus.coef_last = 1'b0;
    case (state_q)
      COLLECT: bus.src_ready = reset;
      EMIT: begin
        bus.dst_valid = 1'b1;
        bus.coef_last = (out_cnt_q == 2'd3);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Row pass: sign-extend the incoming lanes and transform them
  // ---------------------------------------------------------------------------
`ifdef FWD_TRANSFORM_BYPASS_EN
  // Row 0 uses the live pin; later rows use the value captured with row 0.
  assign bypass_row = (in_cnt_q == 2'd0) ? bypass : bypass_q;
`endif

  always_comb begin
    for (int i = 0; i < MB_SIZE; i++) begin
      row_x[i] = {{(CW-PW){bus.residual[(i+1)*PW-1]}}, bus.residual[(i+1)*PW-1 -: PW]};
    end
    for (int i = 0; i < MB_SIZE; i++) begin
      row_y[i] = butterfly(row_x[0], row_x[1], row_x[2], row_x[3], 2'(i));
`ifdef FWD_TRANSFORM_BYPASS_EN
      if (bypass_row) row_y[i] = row_x[i];
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Column pass: lane j of output row out_cnt from column j of H
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int j = 0; j < MB_SIZE; j++) begin
      col_y[j] = butterfly(h_q[0][j], h_q[1][j], h_q[2][j], h_q[3][j], out_cnt_q);
`ifdef FWD_TRANSFORM_BYPASS_EN
      if (bypass_q) col_y[j] = h_q[out_cnt_q][j];
`endif
    end
  end

  // coef is driven only in EMIT so the bus reads zero between blocks.
  always_comb begin
    bus.coef = '0;
    if (state_q == EMIT) begin
      for (int j = 0; j < MB_SIZE; j++) begin
        bus.coef[(j+1)*CW-1 -: CW] = col_y[j];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: intermediate rows and counters
  // in_cnt/out_cnt wrap 3 -> 0 on the block-ending transfer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_cnt_q  <= 2'd0;
      out_cnt_q <= 2'd0;
      for (int r = 0; r < MB_SIZE; r++) begin
        for (int c = 0; c < MB_SIZE; c++) begin
          h_q[r][c] <= '0;
        end
      end
    end else begin
      if (accept_row) begin
        for (int c = 0; c < MB_SIZE; c++) begin
          h_q[in_cnt_q][c] <= row_y[c];
        end
        in_cnt_q <= in_cnt_q + 2'd1;
      end
      if (emit_row) begin
        out_cnt_q <= out_cnt_q + 2'd1;
      end
    end
  end

`ifdef FWD_TRANSFORM_BYPASS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bypass_q <= 1'b0;
    end else if (accept_row && in_cnt_q == 2'd0) begin
      bypass_q <= bypass;
    end
  end
`endif

endmodule

// File: tb/tb_forward_transform_4x4.sv
module tb_forward_transform_4x4;

  localparam int PW = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  forward_transform_4x4_if #(.MB_SIZE(4), .PIXEL_WIDTH(PW), .COEF_WIDTH(CW)) bus();

`ifdef FWD_TRANSFORM_BYPASS_EN
  logic bypass;
`endif

  forward_transform_4x4 #(.MB_SIZE(4), .PIXEL_WIDTH(PW), .COEF_WIDTH(CW)) dut (
    .clk    (clk),
    .reset  (reset),
`ifdef FWD_TRANSFORM_BYPASS_EN
    .bypass (bypass),
`endif
    .bus    (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [4*PW-1:0] pack_row(input int a, input int b, input int c, input int d);
    return {d[PW-1:0], c[PW-1:0], b[PW-1:0], a[PW-1:0]};
  endfunction

  function automatic logic [4*CW-1:0] pack_coef(input int a, input int b, input int c, input int d);
    return {d[CW-1:0], c[CW-1:0], b[CW-1:0], a[CW-1:0]};
  endfunction

  // Drives one row for one clock edge; returns #1 after that edge.
  task automatic send_row(input logic [4*PW-1:0] r);
    bus.residual  = r;
    bus.src_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.src_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    n_checks++;
    if (bus.src_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_src_ready: got %b expected 0", bus.src_ready);
    end
    n_checks++;
    if (bus.dst_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_dst_valid: got %b expected 0", bus.dst_valid);
    end
    n_checks++;
    if (bus.coef_last !== 1'b0) begin
      n_fail++; $display("FAIL reset_coef_last: got %b expected 0", bus.coef_last);
    end
    n_checks++;
    if (bus.coef !== '0) begin
      n_fail++; $display("FAIL reset_coef: got %h expected 0", bus.coef);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.src_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_src_ready: got %b expected 1", bus.src_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_uniform();
    logic [4*CW-1:0] exp_rows [4];
    exp_rows[0] = pack_coef(80, 0, 0, 0);
    for (int k = 1; k < 4; k++) exp_rows[k] = '0;
    for (int r = 0; r < 4; r++) send_row(pack_row(5, 5, 5, 5));
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (bus.dst_valid !== 1'b1 || bus.coef !== exp_rows[k] || bus.coef_last !== (k == 3)) begin
        n_fail++;
        $display("FAIL uniform row%0d: coef=%h valid=%b last=%b, expected coef=%h valid=1 last=%b",
                 k, bus.coef, bus.dst_valid, bus.coef_last, exp_rows[k], (k == 3));
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (bus.dst_valid !== 1'b0 || bus.src_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL uniform_done: valid=%b ready=%b expected valid=0 ready=1", bus.dst_valid, bus.src_ready);
    end
  endtask

  task automatic test_single_row();
    logic [4*CW-1:0] exp_rows [4];
    exp_rows[0] = pack_coef(24, 3, 2, 9);
    exp_rows[1] = pack_coef(48, 6, 4, 18);
    exp_rows[2] = pack_coef(24, 3, 2, 9);
    exp_rows[3] = pack_coef(24, 3, 2, 9);
    send_row(pack_row(8, 4, 7, 5));
    for (int r = 1; r < 4; r++) send_row(pack_row(0, 0, 0, 0));
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (bus.dst_valid !== 1'b1 || bus.coef !== exp_rows[k] || bus.coef_last !== (k == 3)) begin
        n_fail++;
        $display("FAIL single_row row%0d: coef=%h valid=%b last=%b, expected coef=%h valid=1 last=%b",
                 k, bus.coef, bus.dst_valid, bus.coef_last, exp_rows[k], (k == 3));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_min_value();
    logic [4*CW-1:0] exp_rows [4];
    exp_rows[0] = pack_coef(-2048, 0, 0, 0);
    for (int k = 1; k < 4; k++) exp_rows[k] = '0;
    for (int r = 0; r < 4; r++) send_row(pack_row(-128, -128, -128, -128));
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (bus.dst_valid !== 1'b1 || bus.coef !== exp_rows[k] || bus.coef_last !== (k == 3)) begin
        n_fail++;
        $display("FAIL min_value row%0d: coef=%h valid=%b last=%b, expected coef=%h valid=1 last=%b",
                 k, bus.coef, bus.dst_valid, bus.coef_last, exp_rows[k], (k == 3));
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Output stall with src_valid asserted throughout; the extra rows must be ignored.
  task automatic test_stall();
    logic [4*CW-1:0] exp_rows [4];
    exp_rows[0] = pack_coef(24, 3, 2, 9);
    exp_rows[1] = pack_coef(48, 6, 4, 18);
    exp_rows[2] = pack_coef(24, 3, 2, 9);
    exp_rows[3] = pack_coef(24, 3, 2, 9);
    bus.dst_ready = 1'b0;
    send_row(pack_row(8, 4, 7, 5));
    for (int r = 1; r < 4; r++) send_row(pack_row(0, 0, 0, 0));
    bus.residual  = pack_row(99, -77, 55, -33);
    bus.src_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (bus.dst_valid !== 1'b1 || bus.coef !== exp_rows[0] || bus.coef_last !== 1'b0 ||
          bus.src_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall cycle%0d: coef=%h valid=%b last=%b src_ready=%b, expected coef=%h valid=1 last=0 src_ready=0",
                 c, bus.coef, bus.dst_valid, bus.coef_last, bus.src_ready, exp_rows[0]);
      end
      @(posedge clk);
      #1;
    end
    bus.src_valid = 1'b0;
    bus.dst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (bus.dst_valid !== 1'b1 || bus.coef !== exp_rows[k] || bus.coef_last !== (k == 3)) begin
        n_fail++;
        $display("FAIL stall_release row%0d: coef=%h valid=%b last=%b, expected coef=%h valid=1 last=%b",
                 k, bus.coef, bus.dst_valid, bus.coef_last, exp_rows[k], (k == 3));
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Reset after two rows, then a clean block must land with row 0 first.
  task automatic test_reset_mid_block();
    logic [4*CW-1:0] exp_rows [4];
    exp_rows[0] = pack_coef(24, 3, 2, 9);
    exp_rows[1] = pack_coef(48, 6, 4, 18);
    exp_rows[2] = pack_coef(24, 3, 2, 9);
    exp_rows[3] = pack_coef(24, 3, 2, 9);
    send_row(pack_row(100, -50, 3, 7));
    send_row(pack_row(-9, 12, 60, -1));
    reset = 1'b0;
    #2;
    n_checks++;
    if (bus.src_ready !== 1'b0 || bus.dst_valid !== 1'b0 || bus.coef_last !== 1'b0 || bus.coef !== '0) begin
      n_fail++;
      $display("FAIL mid_block_reset: src_ready=%b valid=%b last=%b coef=%h expected 0 0 0 0",
               bus.src_ready, bus.dst_valid, bus.coef_last, bus.coef);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    send_row(pack_row(8, 4, 7, 5));
    for (int r = 1; r < 4; r++) send_row(pack_row(0, 0, 0, 0));
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (bus.dst_valid !== 1'b1 || bus.coef !== exp_rows[k] || bus.coef_last !== (k == 3)) begin
        n_fail++;
        $display("FAIL after_reset row%0d: coef=%h valid=%b last=%b, expected coef=%h valid=1 last=%b",
                 k, bus.coef, bus.dst_valid, bus.coef_last, exp_rows[k], (k == 3));
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Reset during EMIT after one output row; next block must start from row 0.
  task automatic test_reset_mid_emit();
    logic [4*CW-1:0] exp_rows [4];
    exp_rows[0] = pack_coef(80, 0, 0, 0);
    for (int k = 1; k < 4; k++) exp_rows[k] = '0;
    for (int r = 0; r < 4; r++) send_row(pack_row(8, 4, 7, 5));
    @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    n_checks++;
    if (bus.dst_valid !== 1'b0 || bus.coef !== '0 || bus.src_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_emit_reset: valid=%b coef=%h src_ready=%b expected 0 0 0",
               bus.dst_valid, bus.coef, bus.src_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int r = 0; r < 4; r++) send_row(pack_row(5, 5, 5, 5));
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (bus.dst_valid !== 1'b1 || bus.coef !== exp_rows[k] || bus.coef_last !== (k == 3)) begin
        n_fail++;
        $display("FAIL after_emit_reset row%0d: coef=%h valid=%b last=%b, expected coef=%h valid=1 last=%b",
                 k, bus.coef, bus.dst_valid, bus.coef_last, exp_rows[k], (k == 3));
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Second block follows the first with no idle cycle; distinct 2-D pattern.
  task automatic test_back_to_back();
    logic [4*CW-1:0] exp_rows [4];
    for (int r = 0; r < 4; r++) send_row(pack_row(5, 5, 5, 5));
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
    end
    exp_rows[0] = pack_coef(2, 3, 0, -1);
    exp_rows[1] = pack_coef(3, 5, 1, 0);
    exp_rows[2] = pack_coef(0, 1, 2, 3);
    exp_rows[3] = pack_coef(-1, 0, 3, 5);
    send_row(pack_row(1, 0, 0, 0));
    send_row(pack_row(0, 1, 0, 0));
    send_row(pack_row(0, 0, 0, 0));
    send_row(pack_row(0, 0, 0, 0));
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (bus.dst_valid !== 1'b1 || bus.coef !== exp_rows[k] || bus.coef_last !== (k == 3)) begin
        n_fail++;
        $display("FAIL back_to_back row%0d: coef=%h valid=%b last=%b, expected coef=%h valid=1 last=%b",
                 k, bus.coef, bus.dst_valid, bus.coef_last, exp_rows[k], (k == 3));
      end
      @(posedge clk);
      #1;
    end
  endtask

`ifdef FWD_TRANSFORM_BYPASS_EN
  task automatic test_bypass();
    logic [4*CW-1:0] exp_rows [4];
    exp_rows[0] = pack_coef(1, 2, 3, 4);
    exp_rows[1] = pack_coef(-1, 0, 0, 0);
    exp_rows[2] = pack_coef(0, 0, 0, 0);
    exp_rows[3] = pack_coef(127, -128, 0, 1);
    bypass = 1'b1;
    send_row(pack_row(1, 2, 3, 4));
    bypass = 1'b0;
    send_row(pack_row(-1, 0, 0, 0));
    send_row(pack_row(0, 0, 0, 0));
    send_row(pack_row(127, -128, 0, 1));
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (bus.dst_valid !== 1'b1 || bus.coef !== exp_rows[k] || bus.coef_last !== (k == 3)) begin
        n_fail++;
        $display("FAIL bypass row%0d: coef=%h valid=%b last=%b, expected coef=%h valid=1 last=%b",
                 k, bus.coef, bus.dst_valid, bus.coef_last, exp_rows[k], (k == 3));
      end
      @(posedge clk);
      #1;
    end
  endtask
`endif

  initial begin
    bus.residual  = '0;
    bus.src_valid = 1'b0;
    bus.dst_ready = 1'b1;
`ifdef FWD_TRANSFORM_BYPASS_EN
    bypass = 1'b0;
`endif
    test_reset();
    test_uniform();
    test_single_row();
    test_min_value();
    test_stall();
    test_reset_mid_block();
    test_reset_mid_emit();
    test_back_to_back();
`ifdef FWD_TRANSFORM_BYPASS_EN
    test_bypass();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/forward_transform_4x4.md
FORWARD_TRANSFORM_4X4 -- requirements
Module: forward_transform_4x4

Interface
REQ-001 Parameter MB_SIZE, default 4, lanes per row and rows per block; only 4 is supported.
REQ-002 Parameter PIXEL_WIDTH, default 8, bit width of one residual lane, two's complement.
REQ-003 Parameter COEF_WIDTH, default 16, bit width of one output coefficient, two's complement; must be at least PIXEL_WIDTH+6.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 residual  input  PIXEL_WIDTH*MB_SIZE  one residual row from motion_compensation; lane i occupies bits [(i+1)*PIXEL_WIDTH-1 -: PIXEL_WIDTH], lane 0 at the LSB.
REQ-007 src_valid  input  1  residual holds a valid row.
REQ-008 src_ready  output  1  block accepts a row this cycle.
REQ-009 coef  output  COEF_WIDTH*MB_SIZE  one coefficient row; lane packing as REQ-006.
REQ-010 dst_valid  output  1  coef holds a valid row.
REQ-011 dst_ready  input  1  downstream accepts coef this cycle.
REQ-012 coef_last  output  1  high with dst_valid on the 4th (final) row of a block.

Function
REQ-013 A row transfer occurs on a rising edge with src_valid=1 and src_ready=1; an output transfer occurs on a rising edge with dst_valid=1 and dst_ready=1.
REQ-014 FSM has two states: COLLECT (src_ready=1, dst_valid=0) and EMIT (src_ready=0, dst_valid=1).
REQ-015 COLLECT: each accepted row r (r=0..3, from a 2-bit in_cnt) is row-transformed and stored as H[r]; acceptance of row 3 moves to EMIT on the same edge and clears in_cnt.
REQ-016 Row transform per row x0..x3 (sign-extended to COEF_WIDTH): s03=x0+x3, d03=x0-x3, s12=x1+x2, d12=x1-x2; y0=s03+s12, y1=2*d03+d12, y2=s03-s12, y3=d03-2*d12.
REQ-017 EMIT: output row k (2-bit out_cnt) lane j = column transform of H[0..3][j] using the same butterfly as REQ-016, selecting output index k.
REQ-018 Latency: first coef row is valid in the cycle immediately after the edge accepting row 3; one row per cycle while dst_ready=1.
REQ-019 coef_last=1 exactly when out_cnt=3 in EMIT; the transfer of that row returns the FSM to COLLECT and clears out_cnt.
REQ-020 With dst_ready=0 in EMIT, coef, coef_last and dst_valid hold unchanged.
REQ-021 src_valid in EMIT is ignored (no row accepted, H unchanged); src_valid deassertion mid-block in COLLECT simply pauses in_cnt.
REQ-022 No saturation: arithmetic is exact for all inputs given REQ-003.
REQ-023 Bit patterns of residual are taken as signed; upstream wrap-around is not corrected.

Reset
REQ-024 While reset=0: FSM=COLLECT, in_cnt=0, out_cnt=0, src_ready=1 only after reset releases, dst_valid=0, coef_last=0, coef=0, H cleared.
REQ-025 Reset asserted mid-block or mid-EMIT discards the partial block; the first row accepted after release is row 0.

Configuration
REQ-026 Macro FWD_TRANSFORM_BYPASS_EN: when defined, adds input port bypass (1 bit, sampled on acceptance of row 0 and held for the block); bypass=1 makes output row k equal to input row k sign-extended to COEF_WIDTH, same FSM, handshake and latency.
REQ-027 When FWD_TRANSFORM_BYPASS_EN is undefined, the bypass port and its logic do not exist and REQ-016/017 always apply.

Verification
REQ-028 Four rows all lanes 5 (motion_compensation output for curr {15,20,25,30} vs ref {10,15,20,25}) -> row0 = {80,0,0,0}, rows 1-3 all 0, coef_last only on row 3.
REQ-029 Row0 lanes0..3 = {8,4,7,5}, rows 1-3 zero -> rows 0,2,3 = {24,3,2,9}, row1 = {48,6,4,18}.
REQ-030 All lanes -128 (8'h80) -> row0 lane0 = -2048, every other coefficient 0; no overflow.
REQ-031 dst_ready=0 for 5 cycles after first output valid -> coef and dst_valid stable, src_ready=0, rows then emit in order 0..3 with no loss.
REQ-032 reset pulsed low after 2 rows accepted -> outputs at reset values; a following full 4-row block produces correct coefficients unaffected by the discarded rows.
REQ-033 With FWD_TRANSFORM_BYPASS_EN defined and bypass=1, rows {1,2,3,4},{-1,0,0,0},{0,0,0,0},{127,-128,0,1} -> emitted unchanged in order, sign-extended.
